ghr_spec: RTL
=============

GHR_SPEC -- requirements
Module: ghr_spec

Interface
REQ-001 Parameter W, default 8: history length in bits; legal range 2..32.
REQ-002 Parameter D, default 4: number of in-flight unresolved branches tracked; legal range 1..16; need not be a power of two.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 predict_valid  input  1  a branch was predicted at fetch this cycle.
REQ-006 predict_taken  input  1  predicted direction (1 = taken).
REQ-007 predict_ready  output  1  equals !full; a prediction is accepted only when predict_valid & predict_ready.
REQ-008 resolve_valid  input  1  the oldest in-flight branch resolved this cycle; resolution is in program order.
REQ-009 resolve_taken  input  1  actual direction of the resolving branch.
REQ-010 spec_hist  output  W  speculative history; bit 0 is the newest outcome.
REQ-011 arch_hist  output  W  committed history of resolved outcomes only.
REQ-012 mispredict  output  1  registered; high for one cycle after a resolve whose outcome differed from its stored prediction.
REQ-013 inflight  output  $clog2(D+1)  number of unresolved branches held.
REQ-014 err  output  1  sticky; set by a resolve while empty.

Function
REQ-015 Accepted prediction: spec_hist <= {spec_hist[W-2:0], predict_taken}; predict_taken is pushed into the checkpoint queue; inflight +1.
REQ-016 Prediction while full (inflight == D): ignored; no state change.
REQ-017 Resolve with inflight > 0: pop the head prediction bit p; arch_hist <= {arch_hist[W-2:0], resolve_taken}; inflight -1.
REQ-018 Resolve with p == resolve_taken: spec_hist is not modified by the resolve.
REQ-019 Resolve with p != resolve_taken: spec_hist <= {arch_hist[W-2:0], resolve_taken}; queue flushed; inflight <= 0; mispredict <= 1 next cycle.
REQ-020 Mispredict and an accepted prediction in the same cycle: recovery wins; the prediction is discarded; the result is the REQ-019 state.
REQ-021 Correct resolve and an accepted prediction in the same cycle: both take effect; inflight unchanged; spec_hist shifts once, by the prediction.
REQ-022 Resolve with inflight == 0: ignored (arch_hist and spec_hist unchanged); err <= 1.
REQ-023 Queue pointers wrap modulo D explicitly; full = (inflight == D); empty = (inflight == 0).
REQ-024 Invariant: arch_hist equals spec_hist shifted back by inflight positions (low-order bits past the window excluded).
REQ-025 mispredict is low in every cycle that does not follow a REQ-019 event.

Reset
REQ-026 On reset: spec_hist = 0, arch_hist = 0, inflight = 0, mispredict = 0, err = 0, queue pointers = 0.
REQ-027 Reset overrides every simultaneous predict or resolve; asserting reset mid-operation discards all in-flight entries.
REQ-028 Reset is the only way to clear err.

Structure
REQ-029 Shared package ghr_pkg holds the W and D defaults and a W-bit history typedef; the same package is used by the predictor table indexers.
REQ-030 Single sub-module ghr_ckpt_fifo (1-bit wide, D deep, push/pop/flush, occupancy count); all history shifting lives in ghr_spec.

Verification (W=4, D=4)
REQ-031 Reset -> spec_hist=0000, arch_hist=0000, inflight=0, predict_ready=1, err=0.
REQ-032 Predict T,T,N -> spec_hist=0110, arch_hist=0000, inflight=3.
REQ-033 Then resolve T -> arch_hist=0001, spec_hist=0110, inflight=2, mispredict stays 0.
REQ-034 Then resolve N (head predicted T) with a simultaneous predict T -> spec_hist=0010, arch_hist=0010, inflight=0, mispredict=1 for exactly one cycle.
REQ-035 From reset: predict T four times -> inflight=4, predict_ready=0; fifth predict -> spec_hist stays 1111; same cycle predict plus correct resolve while not full -> inflight unchanged.
REQ-036 Resolve while inflight=0 -> err=1, histories unchanged; reset asserted with inflight=3 -> all outputs back to REQ-031 values.

Source files
------------

// File: rtl/ghr_pkg.sv
// Global history register shared definitions.
// Used by the speculative GHR and the predictor table indexers.
package ghr_pkg;

    localparam int GHR_W = 8;
    localparam int GHR_D = 4;

    typedef logic [GHR_W-1:0] ghr_t;

endpackage

// File: rtl/ghr_ckpt_fifo.sv
// Checkpoint queue of predicted directions for unresolved branches.
// 1 bit wide, D deep, with flush and occupancy count.
module ghr_ckpt_fifo
    import ghr_pkg::*;
#(
    parameter int D  = GHR_D,
    parameter int PW = (D > 1) ? $clog2(D) : 1,
    parameter int CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic          din,
    output logic          dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [D-1:0]  mem;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // D need not be a power of two, so wrap by compare, not by overflow.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + PW'(1);
    endfunction

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(D));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wrap_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ghr_spec.sv
// Speculative global history with in-order resolve and
// mispredict recovery from the committed history.
module ghr_spec
    import ghr_pkg::*;
#(
    parameter int W = GHR_W,
    parameter int D = GHR_D
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   predict_valid,
    input  logic                   predict_taken,
    output logic                   predict_ready,
    input  logic                   resolve_valid,
    input  logic                   resolve_taken,
    output logic [W-1:0]           spec_hist,
    output logic [W-1:0]           arch_hist,
    output logic                   mispredict,
    output logic [$clog2(D+1)-1:0] inflight,
    output logic                   err
);

    logic full;
    logic empty;
    logic head;
    logic pred_acc;
    logic res_acc;
    logic mis_ev;
    logic push;

    assign predict_ready = !full;
    assign pred_acc      = predict_valid && !full;
    assign res_acc       = resolve_valid && !empty;
    assign mis_ev        = res_acc && (head != resolve_taken);
    // Recovery discards a same-cycle prediction.
    assign push          = pred_acc && !mis_ev;

    ghr_ckpt_fifo #(
        .D (D)
    ) u_ckpt (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (res_acc),
        .flush (mis_ev),
        .din   (predict_taken),
        .dout  (head),
        .count (inflight),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            spec_hist  <= '0;
            arch_hist  <= '0;
            mispredict <= 1'b0;
            err        <= 1'b0;
        end else begin
            mispredict <= mis_ev;
            if (resolve_valid && empty) begin
                err <= 1'b1;
            end
            if (res_acc) begin
                arch_hist <= {arch_hist[W-2:0], resolve_taken};
            end
            if (mis_ev) begin
                spec_hist <= {arch_hist[W-2:0], resolve_taken};
            end else if (pred_acc) begin
                spec_hist <= {spec_hist[W-2:0], predict_taken};
            end
        end
    end

endmodule
